// File: rtl/zeroheti_irq_ctrl.sv
// rtl/zeroheti_irq_ctrl.sv - Priority interrupt controller with per-line pending/enable/trigger/priority registers
// Registered arbiter presents the highest-priority pending, enabled line above THRESH to the core.
module zeroheti_irq_ctrl #(
    parameter int NumIrqs = 32,
    parameter int NumPrio = 8,
    localparam int IrqW  = $clog2(NumIrqs),
    localparam int PrioW = $clog2(NumPrio)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumIrqs-1:0] irqs_i,
    input  logic               reg_req_i,
    input  logic               reg_we_i,
    input  logic [11:0]        reg_addr_i,
    input  logic [31:0]        reg_wdata_i,
    output logic               reg_gnt_o,
    output logic               reg_rvalid_o,
    output logic [31:0]        reg_rdata_o,
    output logic               irq_valid_o,
    output logic [IrqW-1:0]    irq_id_o,
    output logic [PrioW-1:0]   irq_level_o,
    input  logic               irq_ack_i,
    input  logic [IrqW-1:0]    irq_ack_id_i
);

    logic [NumIrqs-1:0] ip_q, ip_d, ie_q, ie_d, trig_q, trig_d, prev_q;
    logic [PrioW-1:0]   prio_q [NumIrqs];
    logic [PrioW-1:0]   prio_d [NumIrqs];
    logic [PrioW-1:0]   thresh_q, thresh_d;
    logic               rvalid_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               valid_q, valid_d;
    logic [IrqW-1:0]    id_q, id_d;
    logic [PrioW-1:0]   level_q, level_d;

    logic [8:0]         addr_idx;
    logic               addr_line;
    logic               addr_thresh;
    logic [NumIrqs-1:0] hw_set;
    logic               unused_wdata;

    assign addr_idx     = reg_addr_i[10:2];
    assign addr_line    = !reg_addr_i[11] && (reg_addr_i[1:0] == 2'b00);
    assign addr_thresh  = (reg_addr_i == 12'h800);
    assign unused_wdata = ^{reg_wdata_i[31:8+PrioW], reg_wdata_i[7:3]};

    // Level lines set on any high sample; edge lines only when the previous sample was low.
    assign hw_set = irqs_i & ~(trig_q & prev_q);

    always_comb begin
        ip_d     = ip_q;
        ie_d     = ie_q;
        trig_d   = trig_q;
        prio_d   = prio_q;
        thresh_d = thresh_q;
        rdata_d  = '0;
        for (int i = 0; i < NumIrqs; i++) begin
            if (irq_ack_i && (irq_ack_id_i == IrqW'(i))) begin
                ip_d[i] = 1'b0;
            end
            if (reg_req_i && addr_line && (addr_idx == 9'(i))) begin
                if (reg_we_i) begin
                    ip_d[i]   = reg_wdata_i[0];
                    ie_d[i]   = reg_wdata_i[1];
                    trig_d[i] = reg_wdata_i[2];
                    prio_d[i] = reg_wdata_i[8 +: PrioW];
                end else begin
                    rdata_d[0]         = ip_q[i];
                    rdata_d[1]         = ie_q[i];
                    rdata_d[2]         = trig_q[i];
                    rdata_d[8 +: PrioW] = prio_q[i];
                end
            end
            // Hardware set is applied last so it beats ack and software clear.
            if (hw_set[i]) begin
                ip_d[i] = 1'b1;
            end
        end
        if (reg_req_i && addr_thresh) begin
            if (reg_we_i) begin
                thresh_d = reg_wdata_i[PrioW-1:0];
            end else begin
                rdata_d[PrioW-1:0] = thresh_q;
            end
        end
    end

    // Strict greater-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        valid_d = 1'b0;
        id_d    = '0;
        level_d = '0;
        for (int i = 0; i < NumIrqs; i++) begin
            if (ip_q[i] && ie_q[i] && (prio_q[i] > thresh_q) &&
                (!valid_d || (prio_q[i] > level_d))) begin
                valid_d = 1'b1;
                id_d    = IrqW'(i);
                level_d = prio_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip_q     <= '0;
            ie_q     <= '0;
            trig_q   <= '0;
            prev_q   <= '0;
            thresh_q <= '0;
            for (int i = 0; i < NumIrqs; i++) begin
                prio_q[i] <= '0;
            end
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            level_q  <= '0;
        end else begin
            ip_q     <= ip_d;
            ie_q     <= ie_d;
            trig_q   <= trig_d;
            prev_q   <= irqs_i;
            thresh_q <= thresh_d;
            prio_q   <= prio_d;
            rvalid_q <= reg_req_i;
            rdata_q  <= rdata_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            level_q  <= level_d;
        end
    end

    assign reg_gnt_o    = reg_req_i;
    assign reg_rvalid_o = rvalid_q;
    assign reg_rdata_o  = rdata_q;
    assign irq_valid_o  = valid_q;
    assign irq_id_o     = id_q;
    assign irq_level_o  = level_q;

endmodule

// File: doc/zeroheti_irq_ctrl.md
ZEROHETI_IRQ_CTRL -- requirements
Module: zeroheti_irq_ctrl

Interface
- REQ-001 The block SHALL have parameter NumIrqs, default 32, giving the number of external interrupt lines (2..256).
- REQ-002 The block SHALL have parameter NumPrio, default 8, giving the number of priority levels (2..256, power of two); IrqW = $clog2(NumIrqs), PrioW = $clog2(NumPrio).
- REQ-003 The block SHALL have port clk_i, input, width 1: single clock, rising edge.
- REQ-004 The block SHALL have port rst_ni, input, width 1: reset, asynchronous, active-low.
- REQ-005 The block SHALL have port irqs_i, input, width NumIrqs: interrupt lines, already synchronous to clk_i.
- REQ-006 The block SHALL have register ports reg_req_i (in, 1), reg_we_i (in, 1), reg_addr_i (in, 12, byte address), reg_wdata_i (in, 32), reg_gnt_o (out, 1), reg_rvalid_o (out, 1) and reg_rdata_o (out, 32).
- REQ-007 The block SHALL have core-side ports irq_valid_o (out, 1), irq_id_o (out, IrqW), irq_level_o (out, PrioW), irq_ack_i (in, 1) and irq_ack_id_i (in, IrqW).

Function
- REQ-008 Line i SHALL map to a 32-bit register at address 4*i, with fields: bit0 IP (pending), bit1 IE (enable), bit2 TRIG (0 = level, 1 = rising edge), bits[8+PrioW-1:8] PRIO; all other bits read 0.
- REQ-009 Address 0x800 SHALL hold THRESH, bits[PrioW-1:0]; all other addresses read 0, and writes to them (including line index >= NumIrqs) SHALL be ignored.
- REQ-010 reg_gnt_o SHALL equal reg_req_i combinationally.
- REQ-011 reg_rvalid_o SHALL assert exactly one cycle after each granted request (read or write), and reg_rdata_o SHALL carry the read data in that cycle and 0 otherwise.
- REQ-012 A register write SHALL take effect at the clock edge on which it is granted.
- REQ-013 An edge-mode line SHALL keep a per-line previous-value register, and IP SHALL be set on the edge after a cycle where irqs_i[i]=1 and previous=0.
- REQ-014 A level-mode line SHALL set IP on every edge where irqs_i[i]=1.
- REQ-015 IP SHALL clear on an edge where irq_ack_i=1 and irq_ack_id_i=i, or on a software write of IP=0.
- REQ-016 A hardware set SHALL win over a simultaneous ack or software clear on the same line.
- REQ-017 A software write of IP=1 SHALL set IP.
- REQ-018 Candidate lines SHALL be those with IP & IE & (PRIO > THRESH).
- REQ-019 The winner SHALL be the candidate with the highest PRIO; on a tie the lowest index wins.
- REQ-020 irq_valid_o, irq_id_o and irq_level_o SHALL be registered, updated every cycle from the current candidates; with no candidate, valid=0 and id/level=0.
- REQ-021 Latency SHALL be: edge sampled in cycle n, IP=1 in cycle n+1, irq_valid_o=1 in cycle n+2.
- REQ-022 After an ack in cycle n, the acked line SHALL not appear on the outputs from cycle n+2, unless it was re-set per REQ-016.
- REQ-023 An ack with irq_ack_id_i >= NumIrqs, or for a line whose IP=0, SHALL have no effect.
- REQ-024 Changing PRIO, IE or THRESH SHALL affect the outputs two cycles after the write is granted, with no glitch in between.

Reset
- REQ-025 On rst_ni=0, asynchronously, all IP, IE, TRIG and PRIO fields SHALL be 0, THRESH 0 and edge-previous registers 0.
- REQ-026 On rst_ni=0, asynchronously, irq_valid_o, irq_id_o, irq_level_o, reg_rvalid_o and reg_rdata_o SHALL be 0.
- REQ-027 A register request or ack in flight at reset assertion SHALL be discarded, with no rvalid after release.
- REQ-028 The first edge after rst_ni deasserts SHALL be a normal operating cycle.

Verification
- REQ-029 Line 5 is configured with IE=1, TRIG=1, PRIO=3, THRESH=0, and irqs_i[5] pulses high for one cycle at n -> IP5=1 at n+1; irq_valid_o=1, irq_id_o=5, irq_level_o=3 at n+2; ack of id 5 at m -> irq_valid_o=0 at m+2.
- REQ-030 Lines 2 and 9 are both pending and enabled with PRIO 4 and 4 -> id=2; then PRIO9 is written to 6 -> id=9, level=6 two cycles after the grant.
- REQ-031 THRESH=5 with line 3 at PRIO=5 pending -> irq_valid_o stays 0; THRESH is then written to 4 -> valid=1, id=3.
- REQ-032 Level line 7 is held high and acked every cycle -> IP7 remains 1 and irq_valid_o stays 1; in an edge-mode line, an edge coinciding with an ack of that line leaves IP=1.
- REQ-033 A read of 0x014 after writing 0x0000_0302 with NumPrio=8 -> rdata 0x0000_0302 one cycle after grant; a read of 0x7FC with NumIrqs=32 -> 0; a write to 0x100 -> no state change.
- REQ-034 rst_ni is asserted mid-operation with pending lines and valid=1 -> all outputs 0 immediately; after release, no interrupt is presented until a new edge or level arrives.
